data_mem_copy_engine: RTL and testbench



---
 rtl/data_mem_copy_engine.sv | 132 +++++++++++++
 tb/tb_data_mem_copy_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_copy_engine.sv
// Word-by-word block copier driving the data-memory manager port.
// Each word costs READ -> WAIT -> WRITE; bank 3 (addr[17:16] == 2'b11) is never touched.
module data_mem_copy_engine #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      mem_data_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    output logic             mem_wren_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_buf;
    logic [31:0]      r_addr;
    logic             r_wren;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [31:0] w_src_nxt;
    logic [31:0] w_dst_nxt;
    logic        w_start_bad;
    logic        w_next_bad;

    assign w_src_nxt   = r_src + 32'd1;
    assign w_dst_nxt   = r_dst + 32'd1;
    assign w_start_bad = (src_i[17:16] == 2'b11) || (dst_i[17:16] == 2'b11);
    assign w_next_bad  = (w_src_nxt[17:16] == 2'b11) || (w_dst_nxt[17:16] == 2'b11);

    // Outputs are registered for the state being entered, so the address is
    // already on the bus during READ and the write strobe during WRITE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
            r_wren  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src  <= src_i;
                        r_dst  <= dst_i;
                        r_cnt  <= len_i;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len_i == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else if (w_start_bad) begin
                            r_err   <= 1'b1;
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= src_i;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_buf   <= mem_data_i;
                    r_addr  <= r_dst;
                    r_wren  <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_src <= w_src_nxt;
                    r_dst <= w_dst_nxt;
                    r_cnt <= r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else if (w_next_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr  <= w_src_nxt;
                        r_state <= S_READ;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o = r_addr;
    assign mem_data_o = r_buf;
    assign mem_wren_o = r_wren;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule

// File: tb/tb_data_mem_copy_engine.sv
// Randomized and directed bench for data_mem_copy_engine with a behavioural copy model
// and a one-cycle-latency memory manager model.
module tb_data_mem_copy_engine;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start_i;
    logic [31:0] src_i;
    logic [31:0] dst_i;
    logic [15:0] len_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_wren_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 CLK = ~CLK;

    data_mem_copy_engine #(.LEN_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start_i    (start_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .len_i      (len_i),
        .mem_data_i (mem_data_i),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_wren_o (mem_wren_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    // Memory manager model: registered read, write on wren; preload port for the bench.
    logic [31:0] mem [0:262143];
    logic        pl_en;
    logic [17:0] pl_addr;
    logic [31:0] pl_data;
    int unsigned wr_total    = 0;
    int unsigned bank3_total = 0;

    always @(posedge CLK) begin
        mem_data_i <= mem[mem_addr_o[17:0]];
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_wren_o) begin
            mem[mem_addr_o[17:0]] <= mem_data_o;
            wr_total <= wr_total + 1;
            if (mem_addr_o[17:16] == 2'b11) bank3_total <= bank3_total + 1;
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        @(negedge CLK);
        pl_en   = 1'b1;
        pl_addr = a[17:0];
        pl_data = v;
        @(negedge CLK);
        pl_en   = 1'b0;
    endtask

    // Behavioural reference: expected final contents of written words.
    logic [31:0] exp_m [int unsigned];

    function automatic logic [31:0] rd(input int unsigned a);
        if (exp_m.exists(a)) return exp_m[a];
        return mem[a];
    endfunction

    task automatic model(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                         output int unsigned nw, output bit e, output int unsigned dcyc);
        logic [31:0] sa;
        logic [31:0] da;
        exp_m.delete();
        nw = 0;
        e  = 1'b0;
        if (n == 0) begin
            dcyc = 1;
        end else if (s[17:16] == 2'b11 || d[17:16] == 2'b11) begin
            e    = 1'b1;
            dcyc = 1;
        end else begin
            for (int unsigned i = 0; i < n; i++) begin
                sa = s + i;
                da = d + i;
                if (sa[17:16] == 2'b11 || da[17:16] == 2'b11) begin
                    e = 1'b1;
                    break;
                end
                exp_m[int'(da[17:0])] = rd(int'(sa[17:0]));
                nw++;
            end
            dcyc = 3 * nw + 1;
        end
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                       input bit poke_busy, input bit poke_fin, input string tag);
        int unsigned nw, dcyc, cyc, w0, b0, first_wr;
        bit e;
        model(s, d, n, nw, e, dcyc);
        w0 = wr_total;
        b0 = bank3_total;
        first_wr = 0;
        @(negedge CLK);
        src_i = s; dst_i = d; len_i = n[15:0]; start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
        cyc = 1;
        while (!done_o && cyc < 400) begin
            if (mem_wren_o && first_wr == 0) first_wr = cyc;
            if (poke_busy && cyc == 2) begin
                start_i = 1'b1; src_i = $urandom; dst_i = $urandom; len_i = 16'($urandom);
            end else if (poke_busy && cyc == 3) begin
                start_i = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        start_i = 1'b0;
        check({tag, " done_cycle"}, cyc, dcyc);
        check({tag, " err"}, 32'(err_o), 32'(e));
        check({tag, " busy_at_done"}, 32'(busy_o), 32'd1);
        check({tag, " writes"}, wr_total - w0, nw);
        check({tag, " bank3_writes"}, bank3_total - b0, 32'd0);
        if (nw > 0) check({tag, " first_wr_cycle"}, first_wr, 32'd3);
        foreach (exp_m[k]) check($sformatf("%s mem[%05h]", tag, k), mem[k], exp_m[k]);
        if (poke_fin) begin
            start_i = 1'b1; src_i = 32'h40; dst_i = 32'h80; len_i = 16'd3;
            @(negedge CLK);
            start_i = 1'b0;
            check({tag, " fin_start_busy"}, 32'(busy_o), 32'd0);
            check({tag, " fin_start_done"}, 32'(done_o), 32'd0);
        end
    endtask

    task automatic reset_mid_copy();
        logic [31:0] s, d, v0, v1, old2;
        int unsigned w0;
        bit saw_done;
        s = 32'h400;
        d = 32'h500;
        v0 = $urandom; v1 = $urandom;
        poke(s, v0);
        poke(s + 1, v1);
        for (int unsigned i = 2; i < 8; i++) poke(s + i, $urandom);
        poke(d + 2, 32'h5A5A_5A5A);
        old2 = 32'h5A5A_5A5A;
        w0 = wr_total;
        saw_done = 1'b0;
        @(negedge CLK);
        src_i = s; dst_i = d; len_i = 16'd8; start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
        repeat (5) begin
            saw_done |= done_o;
            @(negedge CLK);
        end
        check("rst wren_c6", 32'(mem_wren_o), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst wren", 32'(mem_wren_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        repeat (4) begin
            @(negedge CLK);
            saw_done |= done_o;
        end
        check("rst no_done", 32'(saw_done), 32'd0);
        check("rst writes", wr_total - w0, 32'd2);
        check("rst word0", mem[d[17:0]], v0);
        check("rst word1", mem[d[17:0] + 18'd1], v1);
        check("rst word2", mem[d[17:0] + 18'd2], old2);
    endtask

    initial begin
        logic [31:0] s, d;
        int unsigned n;
        RST = 1'b1; start_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge CLK);
        check("reset addr", mem_addr_o, 32'd0);
        check("reset wdata", mem_data_o, 32'd0);
        check("reset wren", 32'(mem_wren_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        RST = 1'b0;

        poke(32'h10, 32'hDEAD_BEEF);
        run(32'h10, 32'h20, 1, 1'b0, 1'b0, "single");
        check("single mem20", mem[18'h20], 32'hDEAD_BEEF);

        for (int unsigned i = 0; i < 4; i++) poke(32'h0FFFE + i, $urandom);
        run(32'h0FFFE, 32'h1FFFE, 4, 1'b0, 1'b0, "bankx");

        run(32'h200, 32'h30000, 5, 1'b0, 1'b0, "err_dst");
        for (int unsigned i = 0; i < 2; i++) poke(32'h2FFFE + i, $urandom);
        run(32'h2FFFE, 32'h600, 4, 1'b0, 1'b0, "err_src");
        run(32'h10, 32'h20, 0, 1'b0, 1'b1, "len0");

        for (int unsigned i = 0; i < 5; i++) poke(32'h300 + i, $urandom);
        run(32'h300, 32'h340, 5, 1'b1, 1'b0, "busy_start");

        for (int unsigned i = 0; i < 4; i++) poke(32'h100 + i, i + 1);
        run(32'h100, 32'h101, 3, 1'b0, 1'b0, "overlap");
        for (int unsigned i = 0; i < 4; i++) check($sformatf("overlap ones[%0d]", i), mem[18'h100 + 18'(i)], 32'd1);

        reset_mid_copy();

        for (int unsigned t = 0; t < 20; t++) begin
            s = {14'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), 16'($urandom)};
            d = {14'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), 16'($urandom)};
            if ($urandom_range(0, 2) == 0) s[15:0] = 16'hFFF8 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) d[15:0] = 16'hFFF8 + 16'($urandom_range(0, 7));
            n = $urandom_range(0, 10);
            for (int unsigned i = 0; i < n; i++) poke(s + i, $urandom);
            run(s, d, n, (n >= 2) && ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
